// File: rtl/branch_predict_ctrl.sv
// Two-bit saturating-counter branch predictor with Execute-stage mispredict
// detection, PC redirect, pipeline flushes and branch/mispredict counters.
module branch_predict_ctrl #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [XLEN-1:0]  i_PC_F,
    output logic             o_PredTaken_F,
    input  logic             i_BranchInst_E,
    input  logic             i_Branch_E,
    input  logic             i_PredTaken_E,
    input  logic             i_Stall_E,
    input  logic [XLEN-1:0]  i_PC_E,
    input  logic [XLEN-1:0]  i_PCTarget_E,
    input  logic [XLEN-1:0]  i_PCPlus4_E,
    input  logic             i_CntClr,
    output logic             o_Mispredict_E,
    output logic [XLEN-1:0]  o_PCRedirect_E,
    output logic             o_Flush_D,
    output logic             o_Flush_E,
    output logic [CNT_W-1:0] o_BranchCount,
    output logic [CNT_W-1:0] o_MissCount
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    // Saturating 2-bit counter step: taken moves toward 11, not-taken toward 00.
    function automatic logic [1:0] bht_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        case ({taken, cnt})
            3'b1_11: nxt = 2'b11;
            3'b0_00: nxt = 2'b00;
            default: nxt = taken ? (cnt + 2'b01) : (cnt - 2'b01);
        endcase
        return nxt;
    endfunction

    logic [1:0]       bht_r [BHT_ENTRIES];
    logic [CNT_W-1:0] branch_cnt_r;
    logic [CNT_W-1:0] miss_cnt_r;
    logic [IDX_W-1:0] fetch_idx_s;
    logic [IDX_W-1:0] exec_idx_s;
    logic             resolve_s;
    logic             mispredict_s;
    logic [1:0]       bht_next_s;
    logic             unused_pc_bits_s;

    assign fetch_idx_s  = i_PC_F[IDX_W+1:2];
    assign exec_idx_s   = i_PC_E[IDX_W+1:2];
    assign resolve_s    = i_BranchInst_E & ~i_Stall_E;
    assign mispredict_s = resolve_s & (i_Branch_E ^ i_PredTaken_E);
    assign unused_pc_bits_s = ^{i_PC_F[XLEN-1:IDX_W+2], i_PC_F[1:0],
                                i_PC_E[XLEN-1:IDX_W+2], i_PC_E[1:0]};

    // Next value for the Execute-indexed counter.
    always_comb begin
        bht_next_s = bht_step(bht_r[exec_idx_s], i_Branch_E);
    end

    // Redirect mux: corrected PC is the resolved direction's destination.
    always_comb begin
        if (i_Branch_E) begin
            o_PCRedirect_E = i_PCTarget_E;
        end else begin
            o_PCRedirect_E = i_PCPlus4_E;
        end
    end

    // Prediction reads the registered table with no same-cycle bypass.
    assign o_PredTaken_F  = bht_r[fetch_idx_s][1];
    assign o_Mispredict_E = mispredict_s;
    assign o_Flush_D      = mispredict_s;
    assign o_Flush_E      = mispredict_s;
    assign o_BranchCount  = branch_cnt_r;
    assign o_MissCount    = miss_cnt_r;

    // Branch history table: reset to weak-not-taken, train on resolve.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (resolve_s) begin
            bht_r[exec_idx_s] <= bht_next_s;
        end
    end

    // Performance counters: clear wins over a same-cycle increment.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            branch_cnt_r <= {CNT_W{1'b0}};
            miss_cnt_r   <= {CNT_W{1'b0}};
        end else if (i_CntClr) begin
            branch_cnt_r <= {CNT_W{1'b0}};
            miss_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (resolve_s) begin
                branch_cnt_r <= branch_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (mispredict_s) begin
                miss_cnt_r <= miss_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
